rwc_sweep: RTL and testbench
============================

// Module: rwc_sweep
// PURPOSE
//  Challenge sequencer and response collector placed directly upstream of rwc_ctrl.
//  On start it issues NUM_CHAL challenges to consecutive BRAM addresses, then waits for each collision cycle to finish.
//  It folds every rsp_pos/rsp_neg pair into one response bit and packs the bits into 32-bit words.
//  Each word is handed to the PUF readout path over a valid/ready handshake.
// PARAMETERS
//  NUM_CHAL   32    challenges per sweep, 1..1023; words emitted = ceil(NUM_CHAL/32)
//  SETTLE     2     cycles waited after available re-asserts before sampling rsp_*, >=1
//  TIMEOUT    64    max cycles to wait for each available edge before aborting, >=4
// PORTS
//  clk        in   1   single clock; also clocks rwc_ctrl
//  rst        in   1   asynchronous, active-low reset
//  start      in   1   1-cycle pulse; sampled only in IDLE
//  base_addr  in   10  first challenge address, latched on start
//  chal_data  in   32  write pattern for every challenge, latched on start
//  gen_enable out  1   to rwc_ctrl.gen_enable, 1-cycle pulse
//  cha_addr   out  10  to rwc_ctrl.cha_addr; held stable for the whole challenge
//  cha_data   out  32  to rwc_ctrl.cha_data; latched pattern
//  available  in   1   from rwc_ctrl
//  rsp_pos    in   32  from rwc_ctrl
//  rsp_neg    in   32  from rwc_ctrl
//  rsp_word   out  32  packed response bits; bit i = i-th challenge of the word
//  rsp_valid  out  1   rsp_word valid; held until rsp_ready
//  rsp_ready  in   1   downstream accept
//  busy       out  1   high from the cycle after start until the return to IDLE
//  done       out  1   1-cycle pulse when a sweep completes or aborts
//  err        out  1   sticky timeout flag; cleared by the next accepted start
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0: gen_enable, cha_addr, cha_data, rsp_word, rsp_valid, busy, done, err. Counters 0.
//  States and transitions:
//   IDLE    : start=1 -> latch base_addr and chal_data, clear err/bit_cnt/chal_cnt, go ISSUE.
//   ISSUE   : if available=1, assert gen_enable for exactly 1 cycle and go WAIT_LO; otherwise stay.
//             Waiting in ISSUE is also bounded by TIMEOUT.
//   WAIT_LO : wait for available=0, then go WAIT_HI.
//   WAIT_HI : wait for available=1, then go SETTLE.
//   SETTLE  : count SETTLE cycles, then go CAPTURE.
//   CAPTURE : compute bit = ^(rsp_pos ^ rsp_neg) (parity of pos/neg mismatch).
//             Write the bit to rsp_word[bit_cnt]; bit_cnt++ and chal_cnt++.
//             cha_addr = cha_addr+1, wrapping modulo 1024 (1023 -> 0).
//             If bit_cnt reaches 32 or chal_cnt reaches NUM_CHAL, go EMIT; else go ISSUE.
//   EMIT    : rsp_valid=1 with rsp_word stable. On rsp_ready=1:
//              - drop rsp_valid and clear rsp_word/bit_cnt;
//              - go ISSUE if chal_cnt<NUM_CHAL, else pulse done and go IDLE.
//  Partial last word: unused upper bits are 0.
//  Timeout: each of ISSUE, WAIT_LO and WAIT_HI has a cycle counter, reloaded on state entry.
//   On expiry: err=1, done pulse, rsp_valid=0, go IDLE; any partial word is discarded.
//  start outside IDLE is ignored. rsp_ready outside EMIT is ignored.
//  Latency per challenge with rwc_ctrl ideal: ISSUE 1 + rwc_ctrl 3 + WAIT_HI edge 1 + SETTLE + CAPTURE 1 cycles.
//  Asynchronous reset mid-sweep returns to IDLE immediately:
//   gen_enable drops in the same cycle; no word is emitted; the BRAM contents are left unchanged.
// TESTING
//  T1 rwc_ctrl model, start, base_addr=0, NUM_CHAL=32, rsp_pos^rsp_neg parity=1 on odd challenges
//     -> one word 32'hAAAA_AAAA, done pulse, err=0, 32 gen_enable pulses.
//  T2 NUM_CHAL=40, base_addr=10'h3F8 -> cha_addr sequence 3F8..3FF,000..01F;
//     two words emitted, the second with bits[31:8]=0.
//  T3 rsp_ready held 0 for 20 cycles in EMIT -> rsp_valid and rsp_word stable, no gen_enable issued, sweep resumes after ready.
//  T4 available stuck 1 after gen_enable -> err=1 and done pulse TIMEOUT cycles after WAIT_LO entry; busy=0 afterwards.
//  T5 start pulsed again while busy -> ignored, sweep result identical to T1.
//  T6 rst asserted low during SETTLE -> outputs 0 asynchronously; a new start after release runs a clean sweep.

Source files
------------

// File: rtl/rwc_sweep_if.sv
// rwc_sweep_if: all handshake and data signals of rwc_sweep, grouped into one bundle.
//   master : the sweep sequencer. It drives the challenge side toward rwc_ctrl, the response
//            word stream and the status flags.
//   slave  : everything around it, meaning the control source, rwc_ctrl and the readout sink.
// Signals:
//   start, base_addr, chal_data             sweep control into the sequencer
//   gen_enable, cha_addr, cha_data          challenge issue to rwc_ctrl
//   available, rsp_pos, rsp_neg             collision status and responses from rwc_ctrl
//   rsp_word, rsp_valid, rsp_ready          packed response words, valid/ready handshake
//   busy, done, err                         sweep status
interface rwc_sweep_if;
  logic        start;
  logic [9:0]  base_addr;
  logic [31:0] chal_data;
  logic        gen_enable;
  logic [9:0]  cha_addr;
  logic [31:0] cha_data;
  logic        available;
  logic [31:0] rsp_pos;
  logic [31:0] rsp_neg;
  logic [31:0] rsp_word;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        busy;
  logic        done;
  logic        err;

  modport master (
    input  start, base_addr, chal_data, available, rsp_pos, rsp_neg, rsp_ready,
    output gen_enable, cha_addr, cha_data, rsp_word, rsp_valid, busy, done, err
  );

  modport slave (
    output start, base_addr, chal_data, available, rsp_pos, rsp_neg, rsp_ready,
    input  gen_enable, cha_addr, cha_data, rsp_word, rsp_valid, busy, done, err
  );
endinterface

// File: rtl/rwc_sweep.sv
// rwc_sweep: challenge sequencer and response collector that sits in front of rwc_ctrl.
// A start pulse launches a sweep. The sweep issues NUM_CHAL challenges to consecutive addresses,
// beginning at base_addr and wrapping at 1024. For each collision it folds rsp_pos/rsp_neg
// into a single parity bit and packs those bits LSB-first into 32-bit words. Each word leaves
// over a valid/ready handshake.
// Ports:
//   clk  - single clock (shared with rwc_ctrl)
//   rst  - asynchronous active-low reset
//   bus  - rwc_sweep_if.master carrying control, challenge, response and status signals
// Parameters:
//   NUM_CHAL - challenges per sweep (1..1023)
//   SETTLE   - cycles waited after available re-asserts before sampling (>=1)
//   TIMEOUT  - cycle bound on ISSUE / WAIT_LO / WAIT_HI before the sweep aborts (>=4)
module rwc_sweep #(
  parameter int unsigned NUM_CHAL = 32,
  parameter int unsigned SETTLE   = 2,
  parameter int unsigned TIMEOUT  = 64
) (
  input logic          clk,
  input logic          rst,
  rwc_sweep_if.master  bus
);

  typedef enum logic [2:0] {
    StIdle, StIssue, StWaitLo, StWaitHi, StSettle, StCapture, StEmit
  } state_e;

  localparam int unsigned    TmoW     = $clog2(TIMEOUT);
  localparam int unsigned    SetW     = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [TmoW-1:0] TmoLoad = TmoW'(TIMEOUT - 1);
  localparam logic [SetW-1:0] SetLoad = SetW'(SETTLE - 1);
  localparam logic [9:0]     LastChal = 10'(NUM_CHAL);

  state_e          state_q;
  logic            gen_q;
  logic [9:0]      addr_q;
  logic [31:0]     data_q;
  logic [31:0]     word_q;
  logic            valid_q;
  logic            busy_q;
  logic            done_q;
  logic            err_q;
  logic [5:0]      bit_cnt_q;
  logic [9:0]      chal_cnt_q;
  logic [TmoW-1:0] tmo_q;
  logic [SetW-1:0] set_q;

  logic rsp_bit;
  logic evt;
  logic waiting;
  logic abort;
  logic word_full;
  logic sweep_last;

  assign rsp_bit    = ^(bus.rsp_pos ^ bus.rsp_neg);
  assign word_full  = (bit_cnt_q == 6'd31);
  assign sweep_last = ((chal_cnt_q + 10'd1) == LastChal);

  // Event each waiting state is looking for; if it is absent, the timeout counter runs down.
  always_comb begin
    evt = 1'b0;
    unique case (state_q)
      StIssue:  evt = bus.available;
      StWaitLo: evt = !bus.available;
      StWaitHi: evt = bus.available;
      default:  evt = 1'b0;
    endcase
  end

  assign waiting = (state_q == StIssue) || (state_q == StWaitLo) || (state_q == StWaitHi);
  assign abort   = waiting && !evt && (tmo_q == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      gen_q      <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      word_q     <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      bit_cnt_q  <= '0;
      chal_cnt_q <= '0;
      tmo_q      <= '0;
      set_q      <= '0;
    end else begin
      gen_q  <= 1'b0;
      done_q <= 1'b0;
      if (abort) begin
        // Abandon the sweep and drop any partial word.
        err_q   <= 1'b1;
        done_q  <= 1'b1;
        valid_q <= 1'b0;
        word_q  <= '0;
        busy_q  <= 1'b0;
        state_q <= StIdle;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (bus.start) begin
              addr_q     <= bus.base_addr;
              data_q     <= bus.chal_data;
              err_q      <= 1'b0;
              bit_cnt_q  <= '0;
              chal_cnt_q <= '0;
              word_q     <= '0;
              busy_q     <= 1'b1;
              tmo_q      <= TmoLoad;
              state_q    <= StIssue;
            end
          end
          StIssue: begin
            if (evt) begin
              gen_q   <= 1'b1;
              tmo_q   <= TmoLoad;
              state_q <= StWaitLo;
            end else begin
              tmo_q <= tmo_q - 1'b1;
            end
          end
          StWaitLo: begin
            if (evt) begin
              tmo_q   <= TmoLoad;
              state_q <= StWaitHi;
            end else begin
              tmo_q <= tmo_q - 1'b1;
            end
          end
          StWaitHi: begin
            if (evt) begin
              set_q   <= SetLoad;
              state_q <= StSettle;
            end else begin
              tmo_q <= tmo_q - 1'b1;
            end
          end
          StSettle: begin
            if (set_q == '0) begin
              state_q <= StCapture;
            end else begin
              set_q <= set_q - 1'b1;
            end
          end
          StCapture: begin
            word_q[bit_cnt_q[4:0]] <= rsp_bit;
            bit_cnt_q              <= bit_cnt_q + 6'd1;
            chal_cnt_q             <= chal_cnt_q + 10'd1;
            addr_q                 <= addr_q + 10'd1;
            if (word_full || sweep_last) begin
              valid_q <= 1'b1;
              state_q <= StEmit;
            end else begin
              tmo_q   <= TmoLoad;
              state_q <= StIssue;
            end
          end
          StEmit: begin
            if (bus.rsp_ready) begin
              valid_q   <= 1'b0;
              word_q    <= '0;
              bit_cnt_q <= '0;
              if (chal_cnt_q < LastChal) begin
                tmo_q   <= TmoLoad;
                state_q <= StIssue;
              end else begin
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
                state_q <= StIdle;
              end
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign bus.gen_enable = gen_q;
  assign bus.cha_addr   = addr_q;
  assign bus.cha_data   = data_q;
  assign bus.rsp_word   = word_q;
  assign bus.rsp_valid  = valid_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_rwc_sweep.sv
// tb_rwc_sweep: table-driven bench for rwc_sweep. It holds two instances (NUM_CHAL=32 and 40)
// and one shared behavioural rwc_ctrl. The rwc_ctrl model drops available for three cycles
// after each gen_enable. Its response parity equals bit 0 of the challenge address.
module tb_rwc_sweep;
  localparam int unsigned Timeout = 64;

  logic        clk;
  logic        rst;
  logic        start32;
  logic        start40;
  logic [9:0]  base;
  logic [31:0] data;
  logic        rdy;
  logic        sel;
  logic        stuck;
  logic        available;
  logic [31:0] rsp_pos;
  logic [31:0] rsp_neg;
  logic [1:0]  cd;
  logic [9:0]  lat_addr;

  int n_checks;
  int n_fail;

  rwc_sweep_if b32 ();
  rwc_sweep_if b40 ();

  rwc_sweep #(.NUM_CHAL(32), .SETTLE(2), .TIMEOUT(Timeout)) u_dut32 (
    .clk (clk),
    .rst (rst),
    .bus (b32.master)
  );

  rwc_sweep #(.NUM_CHAL(40), .SETTLE(2), .TIMEOUT(Timeout)) u_dut40 (
    .clk (clk),
    .rst (rst),
    .bus (b40.master)
  );

  assign b32.start     = start32;
  assign b40.start     = start40;
  assign b32.base_addr = base;
  assign b40.base_addr = base;
  assign b32.chal_data = data;
  assign b40.chal_data = data;
  assign b32.available = available;
  assign b40.available = available;
  assign b32.rsp_pos   = rsp_pos;
  assign b40.rsp_pos   = rsp_pos;
  assign b32.rsp_neg   = rsp_neg;
  assign b40.rsp_neg   = rsp_neg;
  assign b32.rsp_ready = rdy;
  assign b40.rsp_ready = rdy;

  logic        v_gen, v_valid, v_busy, v_done, v_err;
  logic [9:0]  v_addr;
  logic [31:0] v_data, v_word;
  assign v_gen   = sel ? b40.gen_enable : b32.gen_enable;
  assign v_addr  = sel ? b40.cha_addr   : b32.cha_addr;
  assign v_data  = sel ? b40.cha_data   : b32.cha_data;
  assign v_word  = sel ? b40.rsp_word   : b32.rsp_word;
  assign v_valid = sel ? b40.rsp_valid  : b32.rsp_valid;
  assign v_busy  = sel ? b40.busy       : b32.busy;
  assign v_done  = sel ? b40.done       : b32.done;
  assign v_err   = sel ? b40.err        : b32.err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // rwc_ctrl model: 3-cycle collision. The pos/neg mismatch has odd parity for odd addresses.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      available <= 1'b1;
      cd        <= 2'd0;
      rsp_pos   <= 32'h0;
      rsp_neg   <= 32'h0;
      lat_addr  <= 10'h0;
    end else if (cd != 2'd0) begin
      cd <= cd - 2'd1;
      if (cd == 2'd1) begin
        available <= 1'b1;
        rsp_pos   <= {lat_addr, 22'h1A5C3};
        rsp_neg   <= {lat_addr, 22'h1A5C3} ^ (lat_addr[0] ? 32'h0000_0E00 : 32'h0000_0600);
      end
    end else if (v_gen && !stuck) begin
      available <= 1'b0;
      cd        <= 2'd3;
      lat_addr  <= v_addr;
    end
  end

  typedef struct {
    logic        big;
    logic [9:0]  base;
    logic [31:0] data;
    int          delay;
    logic        stuck;
    logic        restart;
    int          nwords;
    logic [31:0] w0;
    logic [31:0] w1;
    int          pulses;
    logic        err;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic set_start(input logic val);
    if (sel) start40 = val;
    else     start32 = val;
  endtask

  task automatic run_vec(input vec_t v);
    int          npulse;
    int          nw;
    int          hold;
    int          gen_cyc;
    int          done_cyc;
    logic        got_done;
    logic [31:0] held;
    logic [31:0] words[2];
    logic [9:0]  ea;
    sel   = v.big;
    stuck = v.stuck;
    base  = v.base;
    data  = v.data;
    rdy   = 1'b0;
    @(negedge clk);
    set_start(1'b1);
    @(negedge clk);
    set_start(1'b0);
    check("busy_after_start", {31'h0, v_busy}, 32'h1);
    check("err_cleared_on_start", {31'h0, v_err}, 32'h0);
    npulse = 0; nw = 0; hold = 0; gen_cyc = 0; done_cyc = 0;
    got_done = 1'b0; held = 32'h0; words[0] = 32'h0; words[1] = 32'h0;
    for (int cyc = 1; cyc < 3000 && !got_done; cyc++) begin
      @(negedge clk);
      if (v.restart) begin
        if (cyc == 40) begin
          base = 10'h155;
          set_start(1'b1);
        end else if (cyc == 41) begin
          set_start(1'b0);
        end
      end
      if (v_gen) begin
        if (npulse == 0) gen_cyc = cyc;
        ea = v.base + 10'(npulse);
        check("cha_addr", {22'h0, v_addr}, {22'h0, ea});
        check("cha_data", v_data, v.data);
        npulse++;
      end
      if (rdy) begin
        if (nw < 2) words[nw] = held;
        nw++;
        rdy  = 1'b0;
        hold = 0;
      end else if (v_valid) begin
        if (hold == 0) begin
          held = v_word;
        end else begin
          check("word_stable", v_word, held);
          check("no_gen_in_emit", {31'h0, v_gen}, 32'h0);
        end
        if (hold >= v.delay) rdy = 1'b1;
        else hold++;
      end
      if (v_done) begin
        got_done = 1'b1;
        done_cyc = cyc;
      end
    end
    if (!got_done) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_wait: no done within budget, got 0, expected 1");
    end
    check("gen_pulses", npulse, v.pulses);
    check("word_count", nw, v.nwords);
    if (v.nwords >= 1) check("word0", words[0], v.w0);
    if (v.nwords >= 2) check("word1", words[1], v.w1);
    check("err_at_done", {31'h0, v_err}, {31'h0, v.err});
    if (v.stuck) check("timeout_latency", done_cyc - gen_cyc, Timeout);
    @(negedge clk);
    check("done_one_cycle", {31'h0, v_done}, 32'h0);
    check("busy_after_done", {31'h0, v_busy}, 32'h0);
    check("valid_after_done", {31'h0, v_valid}, 32'h0);
    check("err_sticky", {31'h0, v_err}, {31'h0, v.err});
    repeat (3) @(negedge clk);
  endtask

  initial begin
    logic seen_lo;
    logic found;
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b0;
    start32  = 1'b0;
    start40  = 1'b0;
    base     = 10'h0;
    data     = 32'h0;
    rdy      = 1'b0;
    sel      = 1'b0;
    stuck    = 1'b0;

    //         big   base     data          dly stuck rst  nw  w0            w1            pul err
    vecs[0] = '{1'b0, 10'h000, 32'hDEAD_BEEF, 0, 1'b0, 1'b0, 1, 32'hAAAA_AAAA, 32'h0,        32, 1'b0};
    vecs[1] = '{1'b1, 10'h3F8, 32'h1234_5678, 0, 1'b0, 1'b0, 2, 32'hAAAA_AAAA, 32'h0000_00AA, 40, 1'b0};
    vecs[2] = '{1'b1, 10'h000, 32'h0F0F_0F0F, 20, 1'b0, 1'b0, 2, 32'hAAAA_AAAA, 32'h0000_00AA, 40, 1'b0};
    vecs[3] = '{1'b0, 10'h000, 32'hCAFE_F00D, 0, 1'b1, 1'b0, 0, 32'h0,        32'h0,         1, 1'b1};
    vecs[4] = '{1'b0, 10'h000, 32'hDEAD_BEEF, 0, 1'b0, 1'b1, 1, 32'hAAAA_AAAA, 32'h0,        32, 1'b0};
    vecs[5] = '{1'b1, 10'h3FF, 32'h8000_0001, 3, 1'b0, 1'b0, 2, 32'h5555_5555, 32'h0000_0055, 40, 1'b0};

    repeat (3) @(negedge clk);
    check("rst_gen_enable", {31'h0, b32.gen_enable}, 32'h0);
    check("rst_cha_addr", {22'h0, b32.cha_addr}, 32'h0);
    check("rst_cha_data", b32.cha_data, 32'h0);
    check("rst_rsp_word", b32.rsp_word, 32'h0);
    check("rst_flags", {27'h0, b32.rsp_valid, b32.busy, b32.done, b32.err, b40.busy}, 32'h0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Reset asserted while the sweep sits in SETTLE.
    sel   = 1'b0;
    stuck = 1'b0;
    base  = 10'h020;
    data  = 32'h5A5A_5A5A;
    @(negedge clk);
    start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
    seen_lo = 1'b0;
    found   = 1'b0;
    for (int cyc = 0; cyc < 30 && !found; cyc++) begin
      @(negedge clk);
      if (!available) seen_lo = 1'b1;
      else if (seen_lo) found = 1'b1;
    end
    if (!found) begin
      n_checks++;
      n_fail++;
      $display("FAIL settle_wait: available never cycled, got 0, expected 1");
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rst_gen_enable", {31'h0, b32.gen_enable}, 32'h0);
    check("mid_rst_cha_addr", {22'h0, b32.cha_addr}, 32'h0);
    check("mid_rst_cha_data", b32.cha_data, 32'h0);
    check("mid_rst_rsp_word", b32.rsp_word, 32'h0);
    check("mid_rst_flags", {28'h0, b32.rsp_valid, b32.busy, b32.done, b32.err}, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    run_vec(vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end
endmodule
